// File: rtl/quicksort_kv.sv
// Key/payload record buffer with a toggle-command host interface and an in-place
// iterative Lomuto quicksort (ascending or descending) over the stored records.
module quicksort_kv #(
   parameter int K_MSB = 7,
   parameter int V_MSB = 7,
   parameter int P_MSB = 3
) (
   input  logic             clk,
   input  logic             rstn,
   input  logic             enable,
   input  logic             push,
   input  logic             pop,
   input  logic             clear,
   input  logic             sort,
   input  logic             descend,
   input  logic [K_MSB:0]   rx_key,
   input  logic [V_MSB:0]   rx_val,
   output logic [K_MSB:0]   tx_key,
   output logic [V_MSB:0]   tx_val,
   output logic [P_MSB+1:0] count,
   output logic             full,
   output logic             empty,
   output logic             idle,
   output logic             ovf,
   output logic             udf,
   output logic [3:0]       cst,
   output logic [3:0]       nst
);

   localparam int DEPTH = 2**(P_MSB+1);
   localparam int RW    = K_MSB + V_MSB + 2;

   typedef logic [P_MSB+1:0] ptr_t;
   localparam ptr_t ZERO    = '0;
   localparam ptr_t ONE     = ptr_t'(1);
   localparam ptr_t TWO     = ptr_t'(2);
   localparam ptr_t DEPTH_P = ptr_t'(DEPTH);

   typedef enum logic [3:0] {
      IDLE      = 4'b0000,
      CLEAR     = 4'b0001,
      PUSH      = 4'b0011,
      POP       = 4'b0010,
      S_INIT    = 4'b0110,
      S_POPSTK  = 4'b0111,
      S_PIVOT   = 4'b0101,
      S_SCAN    = 4'b0100,
      S_SWAP    = 4'b1100,
      S_PEND    = 4'b1101,
      S_PUSHSTK = 4'b1111,
      S_DONE    = 4'b1110
   } state_t;

   state_t state, next;

   logic [RW-1:0] mem [DEPTH];
   ptr_t          stk_lo [DEPTH];
   ptr_t          stk_hi [DEPTH];

   ptr_t           rd, wr, sp, lo, hi, scan_i, scan_j, sp_top, sp_r;
   logic [K_MSB:0] pivot, key_j;
   logic [RW-1:0]  head, rec_j;
   logic           desc, pass, push_left, push_right;
   logic           sh_push, sh_pop, sh_clear, sh_sort;
   logic           req_push, req_pop, req_clear, req_sort;

   assign req_push  = push  ^ sh_push;
   assign req_pop   = pop   ^ sh_pop;
   assign req_clear = clear ^ sh_clear;
   assign req_sort  = sort  ^ sh_sort;

   assign count = wr - rd;
   assign empty = (count == ZERO);
   assign full  = (wr == DEPTH_P);

   assign head   = mem[rd[P_MSB:0]];
   assign tx_key = empty ? '0 : head[RW-1 -: K_MSB+1];
   assign tx_val = empty ? '0 : head[V_MSB:0];

   assign rec_j = mem[scan_j[P_MSB:0]];
   assign key_j = rec_j[RW-1 -: K_MSB+1];
   assign pass  = desc ? (key_j > pivot) : (key_j < pivot);

   // Sub-ranges of length >= 2 on either side of the final pivot slot scan_i.
   assign push_left  = (scan_i >= lo + TWO);
   assign push_right = (hi >= scan_i + TWO);
   assign sp_top     = sp - ONE;
   assign sp_r       = push_left ? sp + ONE : sp;

   assign cst = state;
   assign nst = next;

   always_comb begin
      next = state;
      if (enable) begin
         case (state)
            IDLE: begin
               if (req_clear)      next = CLEAR;
               else if (req_sort)  next = S_INIT;
               else if (req_pop)   next = POP;
               else if (req_push)  next = PUSH;
            end
            CLEAR, PUSH, POP: next = IDLE;
            S_INIT:    next = (count >= TWO) ? S_POPSTK : S_DONE;
            S_POPSTK:  next = (sp == ZERO) ? S_DONE : S_PIVOT;
            S_PIVOT:   next = S_SCAN;
            S_SCAN: begin
               if (scan_j == hi) next = S_PEND;
               else if (pass)    next = S_SWAP;
            end
            S_SWAP:    next = S_SCAN;
            S_PEND:    next = S_PUSHSTK;
            S_PUSHSTK: next = S_POPSTK;
            S_DONE:    next = IDLE;
            default:   next = IDLE;
         endcase
      end
   end

   always_ff @(posedge clk) begin
      if (!rstn) begin
         state    <= IDLE;
         idle     <= 1'b1;
         rd       <= '0;
         wr       <= '0;
         sp       <= '0;
         lo       <= '0;
         hi       <= '0;
         scan_i   <= '0;
         scan_j   <= '0;
         pivot    <= '0;
         desc     <= 1'b0;
         ovf      <= 1'b0;
         udf      <= 1'b0;
         sh_push  <= push;
         sh_pop   <= pop;
         sh_clear <= clear;
         sh_sort  <= sort;
      end else begin
         sh_push  <= push;
         sh_pop   <= pop;
         sh_clear <= clear;
         sh_sort  <= sort;
         state    <= next;
         idle     <= (next == IDLE);
         if (enable) begin
            case (state)
               IDLE: if (next == S_INIT) desc <= descend;
               CLEAR: begin
                  rd  <= '0;
                  wr  <= '0;
                  sp  <= '0;
                  ovf <= 1'b0;
                  udf <= 1'b0;
               end
               PUSH: if (full) ovf <= 1'b1; else wr <= wr + ONE;
               POP:  if (empty) udf <= 1'b1; else rd <= rd + ONE;
               S_INIT: if (count >= TWO) sp <= ONE;
               S_POPSTK: if (sp != ZERO) begin
                  lo <= stk_lo[sp_top[P_MSB:0]];
                  hi <= stk_hi[sp_top[P_MSB:0]];
                  sp <= sp_top;
               end
               S_PIVOT: begin
                  pivot  <= mem[hi[P_MSB:0]][RW-1 -: K_MSB+1];
                  scan_i <= lo;
                  scan_j <= lo;
               end
               S_SCAN: if (scan_j != hi && !pass) scan_j <= scan_j + ONE;
               S_SWAP: begin
                  scan_i <= scan_i + ONE;
                  scan_j <= scan_j + ONE;
               end
               S_PUSHSTK: sp <= push_right ? sp_r + ONE : sp_r;
               default: ;
            endcase
         end
      end
   end

   // Record storage and range stack carry no reset; pointers define validity.
   always_ff @(posedge clk) begin
      if (rstn && enable) begin
         case (state)
            PUSH: if (!full) mem[wr[P_MSB:0]] <= {rx_key, rx_val};
            S_INIT: if (count >= TWO) begin
               stk_lo[0] <= rd;
               stk_hi[0] <= wr - ONE;
            end
            S_SWAP: begin
               mem[scan_i[P_MSB:0]] <= mem[scan_j[P_MSB:0]];
               mem[scan_j[P_MSB:0]] <= mem[scan_i[P_MSB:0]];
            end
            S_PEND: begin
               mem[scan_i[P_MSB:0]] <= mem[hi[P_MSB:0]];
               mem[hi[P_MSB:0]]     <= mem[scan_i[P_MSB:0]];
            end
            S_PUSHSTK: begin
               if (push_left) begin
                  stk_lo[sp[P_MSB:0]] <= lo;
                  stk_hi[sp[P_MSB:0]] <= scan_i - ONE;
               end
               if (push_right) begin
                  stk_lo[sp_r[P_MSB:0]] <= scan_i + ONE;
                  stk_hi[sp_r[P_MSB:0]] <= hi;
               end
            end
            default: ;
         endcase
      end
   end

endmodule

// File: tb/tb_quicksort_kv.sv
// Directed, table-driven bench for quicksort_kv (DEPTH = 16).
module tb_quicksort_kv;

   logic clk = 1'b0;
   always #5 clk = ~clk;

   logic       rstn, enable, push, pop, clear, sort, descend;
   logic [7:0] rx_key, rx_val, tx_key, tx_val;
   logic [4:0] count;
   logic       full, empty, idle, ovf, udf;
   logic [3:0] cst, nst;

   int tests = 0;
   int fails = 0;

   quicksort_kv #(.K_MSB(7), .V_MSB(7), .P_MSB(3)) dut (
      .clk(clk), .rstn(rstn), .enable(enable),
      .push(push), .pop(pop), .clear(clear), .sort(sort), .descend(descend),
      .rx_key(rx_key), .rx_val(rx_val), .tx_key(tx_key), .tx_val(tx_val),
      .count(count), .full(full), .empty(empty), .idle(idle),
      .ovf(ovf), .udf(udf), .cst(cst), .nst(nst)
   );

   localparam int OP_CLEAR = 0;
   localparam int OP_PUSH  = 1;
   localparam int OP_POP   = 2;
   localparam int OP_SORTA = 3;
   localparam int OP_SORTD = 4;

   typedef struct {
      int         op;
      logic [7:0] k, v;
      logic [4:0] cnt;
      logic       emp, ful, ov, ud;
      logic [7:0] tk, tv;
   } vec_t;

   vec_t vecs[$];

   task automatic add(input int op, input logic [7:0] k, input logic [7:0] v,
                      input logic [4:0] cnt, input logic emp, input logic ful,
                      input logic ov, input logic ud, input logic [7:0] tk,
                      input logic [7:0] tv);
      vec_t r;
      r = '{op, k, v, cnt, emp, ful, ov, ud, tk, tv};
      vecs.push_back(r);
   endtask

   task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
      tests++;
      if (act !== exp) begin
         fails++;
         $display("FAIL %s: got %0h, expected %0h", name, act, exp);
      end
   endtask

   task automatic tick(input int n);
      repeat (n) @(negedge clk);
   endtask

   task automatic do_push(input logic [7:0] k, input logic [7:0] v);
      rx_key = k;
      rx_val = v;
      push   = ~push;
      tick(2);
   endtask

   task automatic do_pop();
      pop = ~pop;
      tick(2);
   endtask

   task automatic do_clear();
      clear = ~clear;
      tick(2);
   endtask

   // Bound is in cycles after the request edge; idle is sampled after each edge.
   task automatic do_sort(input logic d, input int bound, input string name);
      logic done;
      done    = 1'b0;
      descend = d;
      sort    = ~sort;
      for (int c = 1; c <= bound + 1; c++) begin
         tick(1);
         if (idle) begin
            done = 1'b1;
            break;
         end
      end
      check(name, 64'(done), 64'd1);
   endtask

   function automatic int sort_bound(input int n);
      return 4*n*n + 8*n + 8;
   endfunction

   logic [7:0] keys [16];
   logic [7:0] vals [16];
   logic [7:0] rk   [16];
   logic [15:0] seen;
   logic [7:0] prev;
   logic       ok;

   initial begin
      rstn = 1'b0; enable = 1'b1;
      push = 1'b0; pop = 1'b0; clear = 1'b0; sort = 1'b0; descend = 1'b0;
      rx_key = '0; rx_val = '0;

      // Reset values
      tick(2);
      rstn = 1'b1;
      tick(1);
      check("rst_status", 64'({idle, empty, full, ovf, udf}), 64'b11000);
      check("rst_count",  64'(count), 64'd0);
      check("rst_tx",     64'({tx_key, tx_val}), 64'd0);
      check("rst_state",  64'({cst, nst}), 64'd0);

      // Table of single operations with expected status after each
      add(OP_CLEAR, 8'h00, 8'h00, 5'd0, 1, 0, 0, 0, 8'h00, 8'h00);
      add(OP_POP,   8'h00, 8'h00, 5'd0, 1, 0, 0, 1, 8'h00, 8'h00);
      add(OP_PUSH,  8'h07, 8'h11, 5'd1, 0, 0, 0, 1, 8'h07, 8'h11);
      add(OP_PUSH,  8'h02, 8'h22, 5'd2, 0, 0, 0, 1, 8'h07, 8'h11);
      add(OP_CLEAR, 8'h00, 8'h00, 5'd0, 1, 0, 0, 0, 8'h00, 8'h00);
      add(OP_PUSH,  8'h04, 8'h44, 5'd1, 0, 0, 0, 0, 8'h04, 8'h44);
      add(OP_PUSH,  8'h08, 8'h88, 5'd2, 0, 0, 0, 0, 8'h04, 8'h44);
      add(OP_PUSH,  8'h01, 8'h01, 5'd3, 0, 0, 0, 0, 8'h04, 8'h44);
      add(OP_PUSH,  8'h06, 8'h66, 5'd4, 0, 0, 0, 0, 8'h04, 8'h44);
      add(OP_SORTD, 8'h00, 8'h00, 5'd4, 0, 0, 0, 0, 8'h08, 8'h88);
      add(OP_POP,   8'h00, 8'h00, 5'd3, 0, 0, 0, 0, 8'h06, 8'h66);
      add(OP_SORTA, 8'h00, 8'h00, 5'd3, 0, 0, 0, 0, 8'h01, 8'h01);
      add(OP_POP,   8'h00, 8'h00, 5'd2, 0, 0, 0, 0, 8'h04, 8'h44);
      add(OP_POP,   8'h00, 8'h00, 5'd1, 0, 0, 0, 0, 8'h06, 8'h66);
      add(OP_POP,   8'h00, 8'h00, 5'd0, 1, 0, 0, 0, 8'h00, 8'h00);
      add(OP_POP,   8'h00, 8'h00, 5'd0, 1, 0, 0, 1, 8'h00, 8'h00);
      add(OP_PUSH,  8'hFF, 8'hFE, 5'd1, 0, 0, 0, 1, 8'hFF, 8'hFE);
      add(OP_CLEAR, 8'h00, 8'h00, 5'd0, 1, 0, 0, 0, 8'h00, 8'h00);

      foreach (vecs[n]) begin
         case (vecs[n].op)
            OP_CLEAR: do_clear();
            OP_PUSH:  do_push(vecs[n].k, vecs[n].v);
            OP_POP:   do_pop();
            OP_SORTA: do_sort(1'b0, sort_bound(int'(count)), $sformatf("vec%0d_lat", n));
            default:  do_sort(1'b1, sort_bound(int'(count)), $sformatf("vec%0d_lat", n));
         endcase
         check($sformatf("vec%0d", n),
               64'({count, empty, full, ovf, udf, tx_key, tx_val}),
               64'({vecs[n].cnt, vecs[n].emp, vecs[n].ful, vecs[n].ov, vecs[n].ud,
                    vecs[n].tk, vecs[n].tv}));
      end

      // Overflow: 17 pushes into 16 slots
      do_clear();
      for (int k = 0; k < 16; k++) do_push(8'(k), 8'(k + 16));
      check("ovf_pre", 64'({full, count, ovf}), 64'({1'b1, 5'd16, 1'b0}));
      do_push(8'd16, 8'd32);
      check("ovf_post", 64'({full, count, ovf}), 64'({1'b1, 5'd16, 1'b1}));
      ok = 1'b1;
      for (int k = 0; k < 16; k++) begin
         if (tx_key !== 8'(k) || tx_val !== 8'(k + 16)) ok = 1'b0;
         do_pop();
      end
      check("ovf_contents", 64'(ok), 64'd1);
      check("ovf_drained", 64'({empty, tx_key}), 64'({1'b1, 8'd0}));

      // Ascending sort with duplicate keys
      do_clear();
      do_push(8'd5, "A");
      do_push(8'd3, "B");
      do_push(8'd9, "C");
      do_push(8'd3, "D");
      do_push(8'd0, "E");
      do_sort(1'b0, sort_bound(5), "asc_lat");
      for (int n = 0; n < 5; n++) begin
         keys[n] = tx_key;
         vals[n] = tx_val;
         do_pop();
      end
      check("asc_keys", 64'({keys[0], keys[1], keys[2], keys[3], keys[4]}),
            64'({8'd0, 8'd3, 8'd3, 8'd5, 8'd9}));
      check("asc_val0", 64'(vals[0]), 64'("E"));
      check("asc_val12", 64'(({vals[1], vals[2]} == {"B", "D"}) ||
                             ({vals[1], vals[2]} == {"D", "B"})), 64'd1);
      check("asc_val34", 64'({vals[3], vals[4]}), 64'({"A", "C"}));
      check("asc_empty", 64'(empty), 64'd1);

      // Descending sort of 16 random keys
      do_clear();
      for (int n = 0; n < 16; n++) begin
         rk[n] = 8'($urandom_range(0, 255));
         do_push(rk[n], 8'(n));
      end
      do_sort(1'b1, 1160, "desc_lat");
      prev = 8'hFF;
      seen = '0;
      for (int n = 0; n < 16; n++) begin
         check($sformatf("desc_order%0d", n), 64'(tx_key <= prev), 64'd1);
         ok = (tx_val < 8'd16) && (rk[tx_val[3:0]] == tx_key) && !seen[tx_val[3:0]];
         check($sformatf("desc_pair%0d", n), 64'(ok), 64'd1);
         if (tx_val < 8'd16) seen[tx_val[3:0]] = 1'b1;
         prev = tx_key;
         do_pop();
      end

      // Priority: clear beats push in the same cycle
      do_clear();
      for (int n = 0; n < 4; n++) do_push(8'(n), 8'(n));
      rx_key = 8'h55; rx_val = 8'h66;
      clear = ~clear;
      push  = ~push;
      tick(2);
      check("prio_clear", 64'({count, empty}), 64'({5'd0, 1'b1}));

      // Pop toggled while sorting is dropped
      for (int n = 0; n < 4; n++) do_push(8'(4 - n), 8'(n));
      descend = 1'b0;
      sort = ~sort;
      tick(1);
      check("busy_not_idle", 64'(idle), 64'd0);
      pop = ~pop;
      ok = 1'b0;
      for (int c = 0; c < sort_bound(4); c++) begin
         tick(1);
         if (idle) begin
            ok = 1'b1;
            break;
         end
      end
      check("busy_sort_done", 64'(ok), 64'd1);
      tick(2);
      check("busy_pop_dropped", 64'({count, udf, tx_key}), 64'({5'd4, 1'b0, 8'd1}));

      // Latency for 0 and 1 records
      do_clear();
      do_sort(1'b0, 4, "sort_n0_lat");
      do_push(8'd9, 8'd19);
      do_sort(1'b0, 4, "sort_n1_lat");
      check("sort_n1_tx", 64'({count, tx_key, tx_val}), 64'({5'd1, 8'd9, 8'd19}));

      // enable=0 drops requests and freezes a running sort
      enable = 1'b0;
      do_push(8'd1, 8'd1);
      tick(1);
      enable = 1'b1;
      tick(3);
      check("en_push_dropped", 64'(count), 64'd1);
      do_clear();
      for (int n = 0; n < 8; n++) do_push(8'(8 - n), 8'(8 - n));
      sort = ~sort;
      tick(5);
      enable = 1'b0;
      tick(400);
      check("en_frozen", 64'(idle), 64'd0);
      enable = 1'b1;
      ok = 1'b0;
      for (int c = 0; c < sort_bound(8); c++) begin
         tick(1);
         if (idle) begin
            ok = 1'b1;
            break;
         end
      end
      check("en_resume_done", 64'(ok), 64'd1);
      ok = 1'b1;
      for (int n = 1; n <= 8; n++) begin
         if (tx_key !== 8'(n) || tx_val !== 8'(n)) ok = 1'b0;
         do_pop();
      end
      check("en_resume_sorted", 64'(ok), 64'd1);

      // Reset mid-sort aborts and discards
      do_clear();
      for (int n = 0; n < 16; n++) do_push(8'(16 - n), 8'(n));
      sort = ~sort;
      tick(20);
      check("abort_busy", 64'(idle), 64'd0);
      rstn = 1'b0;
      tick(1);
      check("abort_reset", 64'({idle, empty, cst, count}), 64'({1'b1, 1'b1, 4'd0, 5'd0}));
      rstn = 1'b1;
      tick(2);
      check("abort_after", 64'({idle, empty, ovf, udf}), 64'b1100);

      $display("[TB] %0d tests run, %0d failed", tests, fails);
      $finish;
   end

endmodule

// File: doc/quicksort_kv.md
# quicksort_kv

Parametrised successor to the single-channel quicksort buffer. It stores key/payload records, sorts them in place by key in ascending or descending order selected at run time, and drains them in sorted order. It keeps the toggle-command host interface (push/pop/clear/sort), adds sticky overflow and underflow flags and an occupancy count, and exports state for debug. It sits between a producer that fills records and a consumer that pops them once idle.

## Interface
- K_MSB, 7, key MSB; key width K_MSB+1
- V_MSB, 7, payload MSB; payload width V_MSB+1
- P_MSB, 3, pointer MSB; DEPTH = 2**(P_MSB+1) records
- clk  in  1  clock, all logic on rising edge
- rstn  in  1  reset; synchronous and active-low, one clock
- enable  in  1  1 = run; 0 = freeze FSM and storage, commands dropped
- push, pop, clear, sort  in  1 each  toggle commands; every level change is one request
- descend  in  1  order mode, latched when a sort starts; 0 = ascending, 1 = descending
- rx_key  in  K_MSB+1  key written on push
- rx_val  in  V_MSB+1  payload written on push
- tx_key  out  K_MSB+1  key of head record; 0 when empty
- tx_val  out  V_MSB+1  payload of head record; 0 when empty
- count  out  P_MSB+2  records between head and tail
- full, empty, idle  out  1 each  status flags
- ovf, udf  out  1 each  sticky push-when-full / pop-when-empty flags
- cst, nst  out  4  current/next FSM state, Gray-encoded, debug only

## Operation
- Storage: register array mem[DEPTH]. Head pointer rd and tail wr are P_MSB+2 bits wide. count = wr - rd. empty = (count==0). full = (wr==DEPTH); there is no wrap, so after pops the space is only reclaimed by clear.
- Command detect: each command input is sampled into a shadow register every cycle. A request is a mismatch between the input and its shadow. Shadows always update, so a dropped request never fires later.
- Requests are accepted only when cst==IDLE and enable==1. If several arrive in one cycle, only the highest-priority one is taken: clear > sort > pop > push. The others are discarded.
- clear: rd=wr=0, ovf=udf=0. Memory contents are don't-care.
- push: if not full, mem[wr]={rx_key,rx_val} and wr+1. If full, no write and ovf=1.
- pop: if not empty, rd+1. If empty, udf=1.
- sort: sorts mem[rd..wr-1] in place and latches descend.
  - Ascending result: keys non-decreasing from rd. Descending result: keys non-increasing.
  - Each payload stays attached to its key. The order of equal keys is unspecified.
- Sort algorithm: iterative Lomuto quicksort with an explicit (lo,hi) stack of DEPTH entries.
- FSM states: IDLE, CLEAR, PUSH, POP, S_INIT, S_POPSTK, S_PIVOT, S_SCAN, S_SWAP, S_PEND, S_PUSHSTK, S_DONE. Transitions:
  - IDLE goes to CLEAR, PUSH, POP or S_INIT on an accepted request.
  - CLEAR, PUSH and POP return to IDLE.
  - S_INIT pushes (rd, wr-1) if count≥2, else goes to S_DONE.
  - S_POPSTK: if the stack is empty, go to S_DONE. Otherwise pop (lo,hi).
  - S_PIVOT loads pivot = mem[hi] and sets i=lo.
  - S_SCAN iterates j from lo to hi-1. When the compare passes it goes to S_SWAP, which swaps mem[i] with mem[j] and increments i.
  - S_PEND swaps mem[i] with mem[hi].
  - S_PUSHSTK pushes each sub-range of length ≥2.
  - S_DONE goes to IDLE.
- Compare: ascending tests key<pivot; descending tests key>pivot. Compares are unsigned and full width.
- enable=0: the FSM holds its state and there are no memory or pointer updates. Operation resumes where it stopped when enable returns to 1.

## Timing
- Reset (rstn low at an edge) gives:
  - cst=nst=IDLE(0), rd=wr=0, stack empty, all shadows = current inputs
  - count=0, empty=1, full=0, idle=1, ovf=udf=0, tx_key=tx_val=0
- Reset during a sort aborts it and discards all records.
- idle = (cst==IDLE), registered.
- A request seen at edge k moves to the command state at k. Its effect (pointers, flags, count, tx) is visible after edge k+1. idle is low for exactly one cycle for clear, push and pop.
- tx_key/tx_val are combinational from mem[rd] and change in the cycle after a pop or sort completes.
- Sort of N records (N≤1) returns to idle within 4 cycles of the request edge.
- Sort of N records (general) returns to idle within 4·N²+8·N+8 cycles of the request edge.
- nst is the combinational next state; cst is nst registered.

## Test plan
- Reset values: hold rstn=0 for 2 cycles, then release with enable=1.
  - Required: idle=1, empty=1, count=0, full=0, ovf=udf=0, tx=0, cst=0.
- Overflow: DEPTH=16, push 17 records with keys 0..16.
  - Required: full=1, count=16, ovf=1, and key 16 is not stored.
- Ascending sort: push (5,A),(3,B),(9,C),(3,D),(0,E), descend=0, sort, wait for idle, then pop until empty.
  - Required key order: 0,3,3,5,9.
  - Required payloads: E, then {B,D} in either order, A, C.
- Descending sort: push 16 random keys, descend=1, sort.
  - Required: idle returns within 1160 cycles.
  - Required: popped keys are non-increasing and each key/payload pair is preserved.
- Priority: toggle clear and push in the same cycle with 4 records stored.
  - Required: count=0 and no new record.
  - Required: toggling pop while the FSM is not IDLE is dropped (count unchanged).
- Underflow and abort:
  - Pop when empty; required udf=1, which a later clear resets to 0.
  - Pull rstn low mid-sort on 16 records; required idle=1, empty=1 and cst=0 after one edge.
